// File: rtl/clint_timer_if.sv
// ============================================================================
// Module      : clint_timer_if
// Description : req/gnt/rvalid data-bus port for the CLINT timer block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clint_timer_if;
  logic        req_i;
  logic        we_i;
  logic [15:0] addr_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/clint_timer.sv
// ============================================================================
// Module      : clint_timer
// Description : Machine timer/software interrupt source (mtime, mtimecmp, msip).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_timer #(
  parameter int unsigned PRESCALE     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  input  wire logic        time_en_i,
  clint_timer_if.slave     bus,
  output logic             timer_irq_o,
  output logic             soft_irq_o
);

  localparam logic [15:0] c_ADDR_MSIP    = 16'h0000;
  localparam logic [15:0] c_ADDR_CMP_LO  = 16'h4000;
  localparam logic [15:0] c_ADDR_CMP_HI  = 16'h4004;
  localparam logic [15:0] c_ADDR_TIME_LO = 16'hBFF8;
  localparam logic [15:0] c_ADDR_TIME_HI = 16'hBFFC;
  localparam logic [15:0] c_PRESC_MAX    = 16'(PRESCALE - 1);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [15:0] r_presc;
  logic        r_rvalid;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_timer_irq;
  logic        r_soft_irq;

  logic        w_sel_msip, w_sel_cmp_lo, w_sel_cmp_hi, w_sel_time_lo, w_sel_time_hi;
  logic        w_mapped;
  logic        w_wr;
  logic        w_rd;
  logic        w_time_wr;
  logic        w_tick;
  logic [31:0] w_rd_val;
  logic [63:0] w_mtime_wr_val;

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Exact 16-bit compares also reject misaligned offsets.
  assign w_sel_msip    = (bus.addr_i == c_ADDR_MSIP);
  assign w_sel_cmp_lo  = (bus.addr_i == c_ADDR_CMP_LO);
  assign w_sel_cmp_hi  = (bus.addr_i == c_ADDR_CMP_HI);
  assign w_sel_time_lo = (bus.addr_i == c_ADDR_TIME_LO);
  assign w_sel_time_hi = (bus.addr_i == c_ADDR_TIME_HI);
  assign w_mapped      = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi |
                         w_sel_time_lo | w_sel_time_hi;

  assign w_wr      = bus.req_i & bus.we_i & w_mapped;
  assign w_rd      = bus.req_i & ~bus.we_i & w_mapped;
  assign w_time_wr = w_wr & (w_sel_time_lo | w_sel_time_hi);
  assign w_tick    = time_en_i & (r_presc == c_PRESC_MAX);

  always_comb begin
    w_rd_val = 32'd0;
    case (bus.addr_i)
      c_ADDR_MSIP:    w_rd_val = {31'd0, r_msip};
      c_ADDR_CMP_LO:  w_rd_val = r_mtimecmp[31:0];
      c_ADDR_CMP_HI:  w_rd_val = r_mtimecmp[63:32];
      c_ADDR_TIME_LO: w_rd_val = r_mtime[31:0];
      c_ADDR_TIME_HI: w_rd_val = r_mtime[63:32];
      default:        w_rd_val = 32'd0;
    endcase
  end

  always_comb begin
    w_mtime_wr_val = r_mtime;
    if (w_sel_time_lo)
      w_mtime_wr_val[31:0] = f_merge(r_mtime[31:0], bus.wdata_i, bus.be_i);
    else
      w_mtime_wr_val[63:32] = f_merge(r_mtime[63:32], bus.wdata_i, bus.be_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mtime     <= 64'd0;
      r_mtimecmp  <= MTIMECMP_RST;
      r_msip      <= 1'b0;
      r_presc     <= 16'd0;
      r_rvalid    <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
      r_timer_irq <= 1'b0;
      r_soft_irq  <= 1'b0;
    end else begin
      r_rvalid <= bus.req_i;
      r_err    <= bus.req_i & ~w_mapped;
      r_rdata  <= w_rd ? w_rd_val : 32'd0;

      if (w_wr && w_sel_msip && bus.be_i[0]) r_msip <= bus.wdata_i[0];
      if (w_wr && w_sel_cmp_lo)
        r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], bus.wdata_i, bus.be_i);
      if (w_wr && w_sel_cmp_hi)
        r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], bus.wdata_i, bus.be_i);

      // A software write to mtime overrides the increment and restarts the prescaler.
      if (w_time_wr) begin
        r_mtime <= w_mtime_wr_val;
        r_presc <= 16'd0;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
        r_presc <= 16'd0;
      end else if (time_en_i) begin
        r_presc <= r_presc + 16'd1;
      end

      r_timer_irq <= (r_mtime >= r_mtimecmp);
      r_soft_irq  <= r_msip;
    end
  end

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = r_rvalid;
  assign bus.err_o    = r_err;
  assign bus.rdata_o  = r_rdata;
  assign timer_irq_o  = r_timer_irq;
  assign soft_irq_o   = r_soft_irq;

endmodule

`default_nettype wire

// File: tb/tb_clint_timer.sv
// ============================================================================
// Module      : tb_clint_timer
// Description : Self-checking bench for clint_timer at PRESCALE=1 and PRESCALE=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clint_timer;
  localparam int unsigned c_PA = 1;
  localparam int unsigned c_PB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic time_en = 1'b0;
  logic [1:0] ti, si, rv, er, gn;
  logic [31:0] rd [2];

  clint_timer_if bus_a ();
  clint_timer_if bus_b ();

  clint_timer #(.PRESCALE(c_PA)) dut_a (
    .clk_i(clk), .rst_i(rst), .time_en_i(time_en), .bus(bus_a.slave),
    .timer_irq_o(ti[0]), .soft_irq_o(si[0])
  );
  clint_timer #(.PRESCALE(c_PB)) dut_b (
    .clk_i(clk), .rst_i(rst), .time_en_i(time_en), .bus(bus_b.slave),
    .timer_irq_o(ti[1]), .soft_irq_o(si[1])
  );

  assign rv = {bus_b.rvalid_o, bus_a.rvalid_o};
  assign er = {bus_b.err_o, bus_a.err_o};
  assign gn = {bus_b.gnt_o, bus_a.gnt_o};
  assign rd[0] = bus_a.rdata_o;
  assign rd[1] = bus_b.rdata_o;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: architectural register values per instance.
  logic [63:0] m_time [2];
  logic [63:0] m_cmp [2];
  bit          m_msip [2];
  int unsigned m_presc [2];
  int unsigned m_pre [2] = '{c_PA, c_PB};

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          exp_err;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  function automatic bit is_mapped(input logic [15:0] a);
    return a inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [15:0] a);
    case (a)
      16'h0000: return {31'd0, m_msip[d]};
      16'h4000: return m_cmp[d][31:0];
      16'h4004: return m_cmp[d][63:32];
      16'hBFF8: return m_time[d][31:0];
      16'hBFFC: return m_time[d][63:32];
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_time[d] = 64'd0; m_cmp[d] = '1; m_msip[d] = 1'b0; m_presc[d] = 0;
    end
  endtask

  task automatic model_edge(input int d, input bit req, input bit we, input logic [15:0] a,
                            input logic [3:0] be, input logic [31:0] wd, input bit ten);
    bit time_wr;
    time_wr = 1'b0;
    if (req && we && is_mapped(a)) begin
      case (a)
        16'h0000: if (be[0]) m_msip[d] = wd[0];
        16'h4000: m_cmp[d][31:0]   = merge32(m_cmp[d][31:0], wd, be);
        16'h4004: m_cmp[d][63:32]  = merge32(m_cmp[d][63:32], wd, be);
        16'hBFF8: begin m_time[d][31:0]  = merge32(m_time[d][31:0], wd, be);  time_wr = 1'b1; end
        16'hBFFC: begin m_time[d][63:32] = merge32(m_time[d][63:32], wd, be); time_wr = 1'b1; end
        default: ;
      endcase
    end
    if (time_wr) m_presc[d] = 0;
    else if (ten) begin
      m_presc[d]++;
      if (m_presc[d] == m_pre[d]) begin
        m_presc[d] = 0;
        m_time[d]  = m_time[d] + 64'd1;
      end
    end
  endtask

  // One bus cycle on both instances; every output is compared with the model.
  task automatic step(input bit req, input bit we, input logic [15:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input bit ten);
    logic [31:0] exp_rd [2];
    bit exp_t [2], exp_s [2], exp_e;
    bus_a.req_i = req; bus_a.we_i = we; bus_a.addr_i = a; bus_a.be_i = be; bus_a.wdata_i = wd;
    bus_b.req_i = req; bus_b.we_i = we; bus_b.addr_i = a; bus_b.be_i = be; bus_b.wdata_i = wd;
    time_en = ten;
    #1;
    exp_e = req && !is_mapped(a);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("gnt[%0d]", d), gn[d], req);
      exp_rd[d] = (req && !we && is_mapped(a)) ? model_read(d, a) : 32'd0;
      exp_t[d]  = (m_time[d] >= m_cmp[d]);
      exp_s[d]  = m_msip[d];
      model_edge(d, req, we, a, be, wd, ten);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rvalid[%0d] a=%h", d, a), rv[d], req);
      if (req) begin
        chk($sformatf("err[%0d] a=%h", d, a), er[d], exp_e);
        chk($sformatf("rdata[%0d] a=%h", d, a), rd[d], exp_rd[d]);
      end
      chk($sformatf("timer_irq[%0d]", d), ti[d], exp_t[d]);
      chk($sformatf("soft_irq[%0d]", d), si[d], exp_s[d]);
    end
  endtask

  task automatic idle(input int n, input bit ten);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, ten);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.req_i = 1'b0; bus_b.req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rvalid[%0d]", d), rv[d], 1'b0);
      chk($sformatf("rst_err[%0d]", d), er[d], 1'b0);
      chk($sformatf("rst_rdata[%0d]", d), rd[d], 32'd0);
      chk($sformatf("rst_tirq[%0d]", d), ti[d], 1'b0);
      chk($sformatf("rst_sirq[%0d]", d), si[d], 1'b0);
      chk($sformatf("rst_gnt[%0d]", d), gn[d], 1'b0);
    end
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    vec_t vt [14];
    logic [31:0] r1, old_lo [2];
    logic [15:0] addrs [9];
    bit seen;

    bus_a.req_i = 0; bus_a.we_i = 0; bus_a.addr_i = 0; bus_a.be_i = 0; bus_a.wdata_i = 0;
    bus_b.req_i = 0; bus_b.we_i = 0; bus_b.addr_i = 0; bus_b.be_i = 0; bus_b.wdata_i = 0;
    do_reset();

    // Post-reset reads: mtime small and increasing, mtimecmp high word all ones.
    step(1, 0, 16'hBFF8, 4'hF, 0, 1); r1 = rd[0];
    step(1, 0, 16'hBFF8, 4'hF, 0, 1);
    chk("mtime_monotonic", {31'd0, rd[0] > r1}, 1);
    chk("mtime_small", {31'd0, rd[0] < 32'd16}, 1);
    step(1, 0, 16'h4004, 4'hF, 0, 1);
    chk("cmp_hi_rst", rd[0], 32'hFFFF_FFFF);

    // Timer interrupt rise exactly one clock after mtime reaches 0x40.
    step(1, 1, 16'h4004, 4'hF, 32'h0, 1);
    step(1, 1, 16'h4000, 4'hF, 32'h40, 1);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step(0, 0, 16'h0, 4'h0, 0, 1);
      if (ti[0]) begin
        seen = 1;
        chk("irq_rise_mtime", m_time[0], 64'h41);
      end
    end
    if (!seen) chk("irq_rise_timeout", 0, 1);
    step(1, 1, 16'h4000, 4'hF, 32'hFFFF_FFFF, 1);
    chk("irq_hold_at_write", ti[0], 1);
    idle(1, 1);
    chk("irq_fall", ti[0], 0);

    // Software interrupt: visible two edges after the grant edge.
    step(1, 1, 16'h0000, 4'hF, 32'h1, 1);
    chk("sirq_not_yet", si[0], 0);
    idle(1, 1);
    chk("sirq_set", si[0], 1);
    step(1, 1, 16'h0000, 4'hF, 32'hFFFF_FFFE, 1);
    idle(1, 1);
    chk("sirq_clr", si[0], 0);
    step(1, 0, 16'h0000, 4'hF, 0, 1);
    chk("msip_read0", rd[0], 0);

    // mtime wrap.
    step(1, 1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF, 1);
    step(1, 1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF, 1);
    step(1, 0, 16'hBFF8, 4'hF, 0, 1);
    chk("wrap_pre", rd[0], 32'hFFFF_FFFF);
    step(1, 0, 16'hBFFC, 4'hF, 0, 1);
    chk("wrap_hi", rd[0], 32'h0);

    // Prescale rate and freeze.
    step(1, 1, 16'hBFFC, 4'hF, 32'h0, 1);
    step(1, 1, 16'hBFF8, 4'hF, 32'h0, 1);
    idle(12, 1);
    step(1, 0, 16'hBFF8, 4'hF, 0, 0);
    chk("presc1_rate", rd[0], 32'd12);
    chk("presc4_rate", rd[1], 32'd3);
    idle(10, 0);
    step(1, 0, 16'hBFF8, 4'hF, 0, 0);
    chk("freeze_a", rd[0], 32'd12);
    chk("freeze_b", rd[1], 32'd3);

    // Partial mtime write on a tick cycle of the PRESCALE=4 instance.
    for (int i = 0; i < 8 && m_presc[1] != 3; i++) idle(1, 1);
    chk("tick_align", m_presc[1], 3);
    old_lo[0] = m_time[0][31:0]; old_lo[1] = m_time[1][31:0];
    step(1, 1, 16'hBFF8, 4'b0011, 32'h0000_1234, 1);
    step(1, 0, 16'hBFF8, 4'hF, 0, 0);
    chk("be_write_a", rd[0], (old_lo[0] & 32'hFFFF_0000) | 32'h1234);
    chk("be_write_b", rd[1], (old_lo[1] & 32'hFFFF_0000) | 32'h1234);
    idle(3, 1);
    step(1, 0, 16'hBFF8, 4'hF, 0, 1);
    chk("presc_clr_pre", rd[1], (old_lo[1] & 32'hFFFF_0000) | 32'h1234);
    step(1, 0, 16'hBFF8, 4'hF, 0, 0);
    chk("presc_clr_post", rd[1], ((old_lo[1] & 32'hFFFF_0000) | 32'h1234) + 1);

    // Register map vectors, time frozen.
    vt[0]  = '{1, 16'h0000, 4'hF, 32'h1,         0, 0, 32'h0};
    vt[1]  = '{0, 16'h0000, 4'hF, 32'h0,         0, 1, 32'h1};
    vt[2]  = '{1, 16'h0000, 4'hE, 32'h0,         0, 0, 32'h0};
    vt[3]  = '{0, 16'h0000, 4'h0, 32'h0,         0, 1, 32'h1};
    vt[4]  = '{0, 16'h0008, 4'hF, 32'h0,         1, 1, 32'h0};
    vt[5]  = '{0, 16'h4002, 4'hF, 32'h0,         1, 1, 32'h0};
    vt[6]  = '{1, 16'h4000, 4'hF, 32'h1234_5678, 0, 1, 32'h0};
    vt[7]  = '{0, 16'h4000, 4'h0, 32'h0,         0, 1, 32'h1234_5678};
    vt[8]  = '{1, 16'h4004, 4'hF, 32'hFFFF_FFFF, 0, 0, 32'h0};
    vt[9]  = '{1, 16'h4004, 4'h5, 32'hAABB_CCDD, 0, 0, 32'h0};
    vt[10] = '{0, 16'h4004, 4'hF, 32'h0,         0, 1, 32'hFFBB_FFDD};
    vt[11] = '{1, 16'h0010, 4'hF, 32'hDEAD_BEEF, 1, 1, 32'h0};
    vt[12] = '{1, 16'hBFF8, 4'hF, 32'h100,       0, 0, 32'h0};
    vt[13] = '{0, 16'hBFF8, 4'hF, 32'h0,         0, 1, 32'h100};
    for (int i = 0; i < 14; i++) begin
      step(1, vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, 0);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("vec%0d_err[%0d]", i, d), er[d], vt[i].exp_err);
        if (vt[i].chk_rd) chk($sformatf("vec%0d_rd[%0d]", i, d), rd[d], vt[i].exp_rd);
      end
    end

    // Randomized traffic against the model.
    addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
              16'h0008, 16'h4002, 16'h1234, 16'h4001};
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a;
      logic [31:0] wd;
      a  = addrs[$urandom_range(0, 8)];
      wd = $urandom;
      if (a == 16'h4004 || a == 16'hBFFC) wd = $urandom_range(0, 1);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, a, 4'($urandom), wd,
           $urandom_range(0, 7) != 0);
    end

    // Reset during a granted read: no response follows.
    bus_a.req_i = 1; bus_a.we_i = 0; bus_a.addr_i = 16'hBFF8;
    bus_b.req_i = 1; bus_b.we_i = 0; bus_b.addr_i = 16'hBFF8;
    #4 rst = 1'b1;
    bus_a.req_i = 0; bus_b.req_i = 0;
    @(posedge clk); #1;
    chk("rst_drop_rvalid_a", rv[0], 0);
    chk("rst_drop_rvalid_b", rv[1], 0);
    do_reset();
    step(1, 0, 16'h4004, 4'hF, 0, 1);
    chk("post_rst_cmp_hi", rd[1], 32'hFFFF_FFFF);
    step(1, 0, 16'hBFFC, 4'hF, 0, 1);
    chk("post_rst_time_hi", rd[0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Machine-level interrupt source that drives timer_irq_i and soft_irq_i into the CSR file. It is the producer end of the interrupt lines that the CSR file samples into mip.MTIP/mip.MSIP.
- Holds a free-running 64-bit mtime, a 64-bit mtimecmp and a 1-bit msip, all reachable over a simple req/gnt/rvalid data-bus slave port.
- Sits in the core top beside the data memory, addressed by the LSU.

Parameters:
- PRESCALE, 1, clock cycles per mtime increment; legal range 1..65535.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp (no timer interrupt after reset).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- time_en_i  in  1  count enable; 0 freezes mtime and the prescaler (debug halt)
- req_i  in  1  bus request
- we_i  in  1  1 = write, 0 = read
- addr_i  in  16  byte offset within block
- be_i  in  4  byte enables for writes
- wdata_i  in  32  write data
- gnt_o  out  1  grant
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  error response, qualified by rvalid_o
- timer_irq_o  out  1  to CSR file timer_irq_i
- soft_irq_o  out  1  to CSR file soft_irq_i

Behaviour:
- Reset (async, rst_i=1) sets these values:
  - mtime=0, mtimecmp=MTIMECMP_RST, msip=0, prescaler count=0.
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, timer_irq_o=0, soft_irq_o=0.
  - Reset asserted mid-transaction drops the pending response; no rvalid_o follows.
- Register map (32-bit word access):
  - 0x0000 MSIP: bit0 = msip, bits[31:1] read 0, writes ignored.
  - 0x4000 MTIMECMP[31:0]; 0x4004 MTIMECMP[63:32].
  - 0xBFF8 MTIME[31:0]; 0xBFFC MTIME[63:32].
- Handshake:
  - gnt_o = req_i combinationally; the block never stalls.
  - The granted request gets exactly one response: rvalid_o=1 on the next cycle, for one cycle.
  - Back-to-back requests in consecutive cycles are allowed; each produces rvalid_o one cycle later.
  - Reads: rdata_o holds the register value sampled at the grant cycle; bytes are not masked by be_i.
  - Writes: bytes with be_i[n]=1 are merged into the target on the grant-cycle clock edge; rdata_o=0 in the response.
- Errors: an unmapped offset or addr_i[1:0]!=0 gives a response with err_o=1 and rdata_o=0, and no state change.
- Prescaler and mtime increment:
  - When time_en_i=1, the count advances 0..PRESCALE-1.
  - On the cycle the count equals PRESCALE-1, mtime increments by 1 (full 64-bit, wraps 2^64-1 -> 0) and the count returns to 0.
  - With PRESCALE=1, mtime increments every enabled cycle.
- mtime write priority:
  - A granted write to either MTIME half in the same cycle as an increment: the write wins.
  - The new mtime = old mtime with the written bytes merged, with no increment that cycle.
  - The prescaler count is cleared to 0.
  - The other half is unchanged; software handles carry.
- timer_irq_o is registered: timer_irq_o <= (mtime_q >= mtimecmp_q), unsigned 64-bit.
  - It asserts one cycle after the register values satisfy the compare.
  - It deasserts one cycle after a write raises mtimecmp above mtime (level-sensitive; no clear-on-read).
- soft_irq_o is registered from msip and follows an MSIP write by one cycle.
- Read-during-write to the same word in the same cycle cannot occur (single port).
- A read on the cycle mtime increments returns the pre-increment value.

Test Plan:
- Reset with PRESCALE=1, time_en_i=1 -> timer_irq_o=0, soft_irq_o=0; read 0xBFF8 returns a small monotonically increasing value; read 0x4004 returns 0xFFFF_FFFF.
- Write 0x4004=0, 0x4000=0x40 -> timer_irq_o rises exactly one clock after mtime_q reaches 0x40. Then write 0x4000=0xFFFF_FFFF -> timer_irq_o falls one clock after that write's grant edge.
- Write 0x0000=1 -> soft_irq_o=1 two edges after the grant. Write 0x0000=0xFFFF_FFFE -> soft_irq_o=0. Read 0x0000 returns 0.
- Write MTIME lo=0xFFFF_FFFF, hi=0xFFFF_FFFF -> mtime wraps to 0 after one tick. PRESCALE=4: mtime advances exactly once per 4 cycles. time_en_i=0 for 10 cycles: mtime frozen.
- Write MTIME lo=0x1234 with be_i=4'b0011 on a tick cycle -> lo[15:0]=0x1234, no increment, prescaler cleared.
- Read 0x0008 or 0x4002 -> rvalid_o=1, err_o=1, rdata_o=0, no state change. Assert rst_i one cycle after a granted read -> no rvalid_o follows.
